apb_reg_slave: RTL and testbench
================================

# apb_reg_slave

Parametrised APB register-bank slave: the next-generation target behind the APB agent interface, extending the basic PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA bus with PREADY wait states, PSLVERR error response, read-only status registers and optional byte strobes. It sits between the APB fabric and block-level control/status logic. It is the DUT the RAL model mirrors.

## Interface
Parameters:
- DATA_W, 32: data width; one of 8, 16 or 32.
- ADDR_W, 32: PADDR width.
- NUM_REGS, 8: number of word registers; ≥1.
- WAIT_CYCLES, 0: wait states inserted per transfer; 0–15.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from hw_status_i.
- RESET_VAL, 0: DATA_W-bit reset value of every RW register.

Ports:
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte lanes; present only with APB_REG_SLAVE_PSTRB_EN.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error; valid only while PREADY=1.
- hw_status_i  in  NUM_REGS*DATA_W  read values of RO registers (slice i = register i).
- reg_q_o  out  NUM_REGS*DATA_W  current RW register contents (RO slices drive 0).
- wr_pulse_o  out  NUM_REGS  one-cycle pulse after a committed write to register i.

## Operation
- Decode: word index = PADDR >> log2(DATA_W/8). Error when index ≥ NUM_REGS, the low address bits are nonzero, or the access is a write to an RO register.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP on PSEL=1 & PENABLE=0. PENABLE=1 without a preceding setup is ignored; the FSM stays IDLE.
  - SETUP → ACCESS unconditionally. The wait counter is loaded with WAIT_CYCLES and the address, direction and write data are latched.
  - ACCESS: counter decrements while nonzero. PREADY=1 when the counter is 0. On the completion edge, go to SETUP if PSEL=1 & PENABLE=0, otherwise IDLE.
  - PSEL=0 while in ACCESS: abort to IDLE. No write, no pulse, no error.
- Write commit, on the completion edge with no error: register ← PWDATA (byte-masked per strobes). wr_pulse_o[i] is high for the following cycle.
- Errored writes leave all state unchanged and raise no wr_pulse_o.
- Read: PRDATA = register value, or hw_status_i slice for RO registers. Driven only while PREADY=1 & PWRITE=0 & no error; otherwise 0.
- PSLVERR = PREADY & error; otherwise 0.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, wr_pulse_o=0, RW registers=RESET_VAL, FSM=IDLE, counter=0.
- Reset asserted mid-transfer: the transfer is dropped immediately with no commit.
- Transfer length is 2+WAIT_CYCLES cycles from PSEL rise to completion. With WAIT_CYCLES=0, PREADY is high in the first ACCESS cycle.
- Back-to-back transfers need no idle cycle.
- A written value is visible on reg_q_o the cycle after the completion edge. A read immediately following a write returns the new value.
- hw_status_i is sampled combinationally during the completion cycle; no synchronisation is done here.

## Configuration
- APB_REG_SLAVE_PSTRB_EN
  - Defined: the PSTRB port exists; byte lane k is written only when PSTRB[k]=1. A write with PSTRB=0 is legal and commits nothing, but still pulses wr_pulse_o.
  - Undefined: no PSTRB port; all lanes are written.

## Structure
- Package apb_reg_pkg holds:
  - the FSM state enum (IDLE/SETUP/ACCESS);
  - the WAIT counter width constant (4);
  - the address-index helper function;
  - the error-cause typedef (DECERR_RANGE, DECERR_ALIGN, RO_WRITE) used by the bench coverage.
- One sub-module, apb_reg_cell: a single DATA_W register with strobe mask, RO bypass and write pulse. It is instantiated NUM_REGS times by generate.

## Test plan
- Reset, then read index 3 with RESET_VAL=32'hA5A5_0000, WAIT_CYCLES=0 → PRDATA=32'hA5A5_0000, PREADY in 2nd cycle, PSLVERR=0.
- WAIT_CYCLES=3: write 32'hDEAD_BEEF to PADDR 0x8 → PREADY low for 3 ACCESS cycles then high; reg_q_o slice 2 = DEAD_BEEF; wr_pulse_o[2] pulses once.
- Read PADDR 0x40 with NUM_REGS=8 → PSLVERR=1, PRDATA=0. Write PADDR 0x6 → PSLVERR=1, no register changes.
- RO_MASK=8'h01, hw_status_i[31:0]=32'h1234_5678: read 0x0 → PRDATA=32'h1234_5678. Write 0x0 → PSLVERR=1, no wr_pulse_o.
- With PSTRB_EN: register holds 32'h1111_1111; write 32'hFFFF_FFFF with PSTRB=4'b0101 → register reads 32'h11FF_11FF.
- Drop PSEL mid-ACCESS with WAIT_CYCLES=2, then assert PRESETn=0 during a later write's SETUP → no commit in either case; outputs at reset values.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register-bank slave.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package apb_reg_pkg;

    // Bus phase of the slave. SETUP is normally recognised in the same cycle
    // it appears on the bus, so it is rarely held in the state register.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Width of the wait-state counter (WAIT_CYCLES is at most 15).
    localparam int WAIT_CNT_W = 4;

    // Reason a transfer is answered with PSLVERR.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        DECERR_RANGE = 2'd1,
        DECERR_ALIGN = 2'd2,
        RO_WRITE     = 2'd3
    } err_cause_t;

    // Word index from a byte address. lane_bits is log2 of the bytes per word.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned lane_bits);
        return addr >> lane_bits;
    endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One DATA_W-wide register with byte-lane write mask, read-only bypass and write pulse.
// Latency: written data visible on reg_q_o and wr_pulse_o one cycle after we_i.
// Backpressure: none; we_i is a single-cycle commit strobe and is always accepted.
module apb_reg_cell #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                IS_RO     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   strb_i,
    input  logic [DATA_W-1:0]     hw_status_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [DATA_W-1:0]     reg_q_o,
    output logic                  wr_pulse_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              pulse_q, pulse_d;

    // Merge enabled byte lanes of the write data; read-only cells never change.
    always_comb begin
        data_d  = data_q;
        pulse_d = we_i && !IS_RO;
        if (we_i && !IS_RO) begin
            for (int k = 0; k < DATA_W / 8; k++) begin
                if (strb_i[k]) begin
                    data_d[k*8 +: 8] = wdata_i[k*8 +: 8];
                end
            end
        end
    end

    // Register storage and the one-cycle write pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= RESET_VAL;
            pulse_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            pulse_q <= pulse_d;
        end
    end

    assign rdata_o    = IS_RO ? hw_status_i : data_q;
    assign reg_q_o    = IS_RO ? '0 : data_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/apb_reg_slave.sv
// APB register bank: NUM_REGS word registers, RO status bypass, PSLVERR on bad decode. Optional PSTRB via APB_REG_SLAVE_PSTRB_EN.
// Latency: 2+WAIT_CYCLES cycles from PSEL rise to PREADY; write visible on reg_q_o the cycle after.
// Backpressure: PREADY held low for WAIT_CYCLES access cycles; dropping PSEL in ACCESS aborts the transfer.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
`ifdef APB_REG_SLAVE_PSTRB_EN
    input  logic [DATA_W/8-1:0]          PSTRB,
`endif
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int LANE_BITS = $clog2(STRB_W);

    apb_state_t                   state_q, state_d, phase;
    logic [WAIT_CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         write_q, write_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic [STRB_W-1:0]            strb_q, strb_d;
    logic [STRB_W-1:0]            bus_strb;

    logic [63:0]                  idx;
    logic [NUM_REGS-1:0]          hit;
    logic [NUM_REGS-1:0]          commit;
    logic                         err_range, err_align, err_ro, err;
    logic                         done;
    logic [NUM_REGS-1:0][DATA_W-1:0] cell_rdata;

`ifdef APB_REG_SLAVE_PSTRB_EN
    assign bus_strb = PSTRB;
`else
    assign bus_strb = '1;
`endif

    // Next-state: setup is detected on the bus combinationally so the access
    // phase starts on the following cycle; address/direction/data latch here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        phase   = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            phase = SETUP;
        end
        case (phase)
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                addr_d  = PADDR;
                write_d = PWRITE;
                wdata_d = PWDATA;
                strb_d  = bus_strb;
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    state_d = PENABLE ? IDLE : SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and latched transfer attributes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // Address decode and error classification on the latched address.
    always_comb begin
        idx       = word_index(64'(addr_q), LANE_BITS);
        err_range = idx >= 64'(NUM_REGS);
        err_align = (64'(addr_q) & 64'(STRB_W - 1)) != 64'd0;
        hit       = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (idx == 64'(i));
        end
        err_ro = write_q && ((hit & RO_MASK) != '0);
        err    = err_range || err_align || err_ro;
    end

    assign done   = (state_q == ACCESS) && PSEL && (cnt_q == '0);
    assign commit = {NUM_REGS{done && write_q && !err}} & hit;

    // Bus response: data only on a clean read completion, error only with PREADY.
    always_comb begin
        PREADY  = done;
        PSLVERR = done && err;
        PRDATA  = '0;
        if (done && !write_q && !err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hit[i]) begin
                    PRDATA = cell_rdata[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        apb_reg_cell #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL),
            .IS_RO     (RO_MASK[i])
        ) u_cell (
            .clk         (PCLK),
            .rst_n       (PRESETn),
            .we_i        (commit[i]),
            .wdata_i     (wdata_q),
            .strb_i      (strb_q),
            .hw_status_i (hw_status_i[i*DATA_W +: DATA_W]),
            .rdata_o     (cell_rdata[i]),
            .reg_q_o     (reg_q_o[i*DATA_W +: DATA_W]),
            .wr_pulse_o  (wr_pulse_o[i])
        );
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: directed corner cases then random APB traffic.
// Latency: each transfer is checked for exactly 2+WAIT_CYCLES cycles to PREADY.
// Backpressure: waits for PREADY are bounded; an overrun counts as a failed check.
module tb_apb_reg_slave;
    import apb_reg_pkg::*;

    localparam int              DW    = 32;
    localparam int              NR    = 8;
    localparam int              WAITS = 2;
    localparam logic [NR-1:0]   RO    = 8'h81;
    localparam logic [DW-1:0]   RST_V = 32'hA5A5_0000;

    logic              PCLK = 1'b0;
    logic              PRESETn, PSEL, PENABLE, PWRITE;
    logic [31:0]       PADDR, PWDATA, PRDATA;
    logic [3:0]        PSTRB;
    logic              PREADY, PSLVERR;
    logic [NR*DW-1:0]  hw_status_i, reg_q_o;
    logic [NR-1:0]     wr_pulse_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [NR];

    always #5 PCLK = ~PCLK;

    apb_reg_slave #(
        .DATA_W(DW), .ADDR_W(32), .NUM_REGS(NR), .WAIT_CYCLES(WAITS),
        .RO_MASK(RO), .RESET_VAL(RST_V)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_REG_SLAVE_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .hw_status_i(hw_status_i), .reg_q_o(reg_q_o), .wr_pulse_o(wr_pulse_o)
    );

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Error cause straight from the address map rules.
    function automatic err_cause_t classify(input bit wr, input logic [31:0] addr);
        if (addr % 4 != 0)            return DECERR_ALIGN;
        if (addr / 4 >= NR)           return DECERR_RANGE;
        if (wr && RO[addr / 4])       return RO_WRITE;
        return ERR_NONE;
    endfunction

    function automatic logic [255:0] exp_regq();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) if (!RO[i]) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = RST_V;
    endtask

    // One complete transfer; b2b starts the setup phase without an idle cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input bit b2b);
        err_cause_t  cause;
        int          cycles, idx;
        logic [31:0] exp_rd;
        logic [3:0]  eff;
        logic [NR-1:0] exp_p;
        cause = classify(wr, addr);
        idx   = int'(addr >> 2);
        if (!b2b) begin @(posedge PCLK); #1; end
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
        if (!b2b) begin @(negedge PCLK); chk("ready_in_setup", PREADY, 0); end
        @(posedge PCLK); #1; PENABLE = 1;
        cycles = 1;
        do begin @(negedge PCLK); cycles++; end while (!PREADY && cycles < 40);
        chk("latency", cycles, 2 + WAITS);
        exp_rd = '0;
        if (!wr && cause == ERR_NONE) exp_rd = RO[idx] ? hw_status_i[idx*32 +: 32] : model[idx];
        chk("pslverr", PSLVERR, cause != ERR_NONE);
        chk("prdata", PRDATA, exp_rd);
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
        exp_p = '0;
        if (wr && cause == ERR_NONE) begin
            eff = st;
`ifndef APB_REG_SLAVE_PSTRB_EN
            eff = 4'hF;
`endif
            for (int k = 0; k < 4; k++) if (eff[k]) model[idx][k*8 +: 8] = wd[k*8 +: 8];
            exp_p[idx] = 1'b1;
        end
        @(negedge PCLK);
        chk("ready_after", PREADY, 0);
        chk("wr_pulse", wr_pulse_o, exp_p);
        chk("reg_q", reg_q_o, exp_regq());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          r;
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; PSTRB = '0;
        for (int i = 0; i < NR; i++) hw_status_i[i*32 +: 32] = $urandom();
        model_reset();
        repeat (2) @(negedge PCLK);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pulse", wr_pulse_o, 0);
        chk("rst_regq", reg_q_o, exp_regq());
        PRESETn = 1;

        // Reset value readback, write then immediate readback.
        xfer(0, 32'h0C, 32'h0, 4'hF, 0);
        xfer(1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0);
        xfer(0, 32'h08, 32'h0, 4'hF, 1);
        // Decode errors.
        xfer(0, 32'h40, 32'h0, 4'hF, 0);
        xfer(1, 32'h06, 32'hCAFE_F00D, 4'hF, 0);
        // Read-only status register.
        hw_status_i[31:0] = 32'h1234_5678;
        xfer(0, 32'h00, 32'h0, 4'hF, 0);
        xfer(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 0);
        // Byte strobes, including an all-lanes-off write.
        xfer(1, 32'h10, 32'h1111_1111, 4'hF, 0);
        xfer(1, 32'h10, 32'hFFFF_FFFF, 4'b0101, 1);
        xfer(0, 32'h10, 32'h0, 4'hF, 1);
        xfer(1, 32'h14, 32'h7777_7777, 4'h0, 0);

        // Abort by dropping PSEL during the wait states.
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'h5555_AAAA; PSTRB = 4'hF;
        @(posedge PCLK); #1; PENABLE = 1;
        @(negedge PCLK); chk("abort_wait", PREADY, 0);
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        chk("abort_ready", PREADY, 0);
        chk("abort_err", PSLVERR, 0);
        repeat (3) begin @(negedge PCLK); chk("abort_pulse", wr_pulse_o, 0); end
        chk("abort_regq", reg_q_o, exp_regq());
        xfer(0, 32'h04, 32'h0, 4'hF, 0);

        // Reset during the setup phase of a write.
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h08; PWDATA = 32'h0BAD_F00D; PSTRB = 4'hF;
        @(negedge PCLK); PRESETn = 0;
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
        model_reset();
        @(negedge PCLK);
        chk("mid_rst_pready", PREADY, 0);
        chk("mid_rst_pslverr", PSLVERR, 0);
        chk("mid_rst_prdata", PRDATA, 0);
        chk("mid_rst_pulse", wr_pulse_o, 0);
        chk("mid_rst_regq", reg_q_o, exp_regq());
        PRESETn = 1;
        xfer(0, 32'h08, 32'h0, 4'hF, 0);

        // Random traffic against the model.
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NR; i++) hw_status_i[i*32 +: 32] = $urandom();
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, NR - 1)) * 4;
            else if (r == 7) a = 32'h20 + 32'($urandom_range(0, 15)) * 4;
            else if (r == 8) a = 32'($urandom_range(0, NR - 1)) * 4 + 32'($urandom_range(1, 3));
            else             a = $urandom();
            d = $urandom();
            xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
